inst_loader: RTL and testbench

Program loader that receives an instruction image over UART (8N1) and writes it word by word into the instruction BRAM write port. It feeds the memory the fetch stage reads in LOAD mode, so it is the writer side of that load path. Bytes are packed little-endian into 32-bit words and written to consecutive word addresses from 0. The image ends with the terminator word 32'h0000_003F, which is itself written before `done` rises.

---
 rtl/inst_loader.sv | 272 +++++++++++++++++++++++++++
 tb/tb_inst_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// UART program loader: receives 8N1 bytes, packs them little-endian into 32-bit
// words and writes them to consecutive instruction BRAM addresses until the terminator.
module inst_loader #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int ADDR_W           = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              rxd,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                CNT_W     = $clog2(2 * CLK_PER_HALF_BIT + 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   WC_ZERO   = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   WC_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]       TERM_WORD = 32'h0000_003F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    function automatic logic is_term(input logic [31:0] w);
        return (w == TERM_WORD);
    endfunction

    top_state_t        top_state_r, top_next_s;
    rx_state_t         rx_state_r, rx_next_s;
    logic              rxd_meta_r, rxd_sync_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r;
    logic              brk_r;
    logic [1:0]        byte_idx_r;
    logic [23:0]       word_r;
    logic              wea_r;
    logic [ADDR_W-1:0] addra_r;
    logic [31:0]       dina_r;
    logic [ADDR_W:0]   word_count_r;
    logic              busy_r, done_r, err_r;
    logic              busy_s, done_s, enter_load_s, rx_en_s;
    logic              end_load_s, overflow_s;
    logic              data_tick_s, byte_ok_s, frame_err_s;

    // Two-flop synchronizer for the asynchronous serial input (idles high).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    // Decode of the word just written: terminator or last addressable word ends the session.
    always_comb begin
        end_load_s = 1'b0;
        overflow_s = 1'b0;
        if (wea_r) begin
            end_load_s = is_term(dina_r) || (addra_r == ADDR_MAX);
            overflow_s = !is_term(dina_r) && (addra_r == ADDR_MAX);
        end else begin
            end_load_s = 1'b0;
            overflow_s = 1'b0;
        end
    end

    // Top FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            top_state_r <= S_IDLE;
        end else begin
            top_state_r <= top_next_s;
        end
    end

    // Top FSM next-state logic; start is only honoured outside LOAD.
    always_comb begin
        top_next_s = top_state_r;
        case (top_state_r)
            S_IDLE: begin
                if (start) top_next_s = S_LOAD;
                else       top_next_s = S_IDLE;
            end
            S_LOAD: begin
                if (end_load_s) top_next_s = S_DONE;
                else            top_next_s = S_LOAD;
            end
            S_DONE: begin
                if (start) top_next_s = S_LOAD;
                else       top_next_s = S_DONE;
            end
            default: top_next_s = S_IDLE;
        endcase
    end

    // Top FSM outputs; busy/done are registered from the next state.
    always_comb begin
        busy_s       = (top_next_s == S_LOAD);
        done_s       = (top_next_s == S_DONE);
        rx_en_s      = (top_state_r == S_LOAD);
        enter_load_s = 1'b0;
        if (top_state_r != S_LOAD) begin
            enter_load_s = start;
        end else begin
            enter_load_s = 1'b0;
        end
    end

    // RX FSM state register; held in R_IDLE whenever not loading.
    always_ff @(posedge clk) begin
        if (!rstn || !rx_en_s) begin
            rx_state_r <= R_IDLE;
        end else begin
            rx_state_r <= rx_next_s;
        end
    end

    // RX FSM next-state logic; after a framing error R_STOP waits for the line to idle.
    always_comb begin
        rx_next_s = rx_state_r;
        case (rx_state_r)
            R_IDLE: begin
                if (!rxd_sync_r) rx_next_s = R_START;
                else             rx_next_s = R_IDLE;
            end
            R_START: begin
                if (cnt_r == HALF_LAST) rx_next_s = rxd_sync_r ? R_IDLE : R_DATA;
                else                    rx_next_s = R_START;
            end
            R_DATA: begin
                if ((cnt_r == BIT_LAST) && (bit_idx_r == 3'd7)) rx_next_s = R_STOP;
                else                                            rx_next_s = R_DATA;
            end
            R_STOP: begin
                if (brk_r || (cnt_r == BIT_LAST)) rx_next_s = rxd_sync_r ? R_IDLE : R_STOP;
                else                              rx_next_s = R_STOP;
            end
            default: rx_next_s = R_IDLE;
        endcase
    end

    // RX FSM outputs: data-bit sample strobe and stop-bit verdict.
    always_comb begin
        data_tick_s = 1'b0;
        byte_ok_s   = 1'b0;
        frame_err_s = 1'b0;
        case (rx_state_r)
            R_DATA: data_tick_s = (cnt_r == BIT_LAST);
            R_STOP: begin
                if (!brk_r && (cnt_r == BIT_LAST)) begin
                    byte_ok_s   = rxd_sync_r;
                    frame_err_s = !rxd_sync_r;
                end else begin
                    byte_ok_s   = 1'b0;
                    frame_err_s = 1'b0;
                end
            end
            default: data_tick_s = 1'b0;
        endcase
    end

    // RX bit timer, bit counter and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!rstn || !rx_en_s) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            brk_r     <= 1'b0;
        end else begin
            case (rx_state_r)
                R_IDLE: begin
                    cnt_r     <= CNT_ZERO;
                    bit_idx_r <= 3'd0;
                    brk_r     <= 1'b0;
                end
                R_START: begin
                    cnt_r <= (cnt_r == HALF_LAST) ? CNT_ZERO : (cnt_r + CNT_ONE);
                end
                R_DATA: begin
                    if (data_tick_s) begin
                        cnt_r     <= CNT_ZERO;
                        bit_idx_r <= bit_idx_r + 3'd1;
                        shift_r   <= {rxd_sync_r, shift_r[7:1]};
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                R_STOP: begin
                    cnt_r <= (brk_r || (cnt_r == BIT_LAST)) ? CNT_ZERO : (cnt_r + CNT_ONE);
                    if (frame_err_s) begin
                        brk_r <= 1'b1;
                    end
                end
                default: cnt_r <= CNT_ZERO;
            endcase
        end
    end

    // Word assembly, BRAM write port, session counters and status flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_idx_r   <= 2'd0;
            word_r       <= 24'd0;
            wea_r        <= 1'b0;
            addra_r      <= {ADDR_W{1'b0}};
            dina_r       <= 32'd0;
            word_count_r <= WC_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            wea_r  <= 1'b0;
            if (enter_load_s) begin
                byte_idx_r   <= 2'd0;
                word_r       <= 24'd0;
                word_count_r <= WC_ZERO;
                err_r        <= 1'b0;
            end else if (top_state_r == S_LOAD) begin
                if (overflow_s || frame_err_s) begin
                    err_r <= 1'b1;
                end
                if (byte_ok_s) begin
                    byte_idx_r <= byte_idx_r + 2'd1;
                    case (byte_idx_r)
                        2'd0:    word_r[7:0]   <= shift_r;
                        2'd1:    word_r[15:8]  <= shift_r;
                        2'd2:    word_r[23:16] <= shift_r;
                        default: begin
                            wea_r        <= 1'b1;
                            addra_r      <= word_count_r[ADDR_W-1:0];
                            dina_r       <= {shift_r, word_r};
                            word_count_r <= word_count_r + WC_ONE;
                        end
                    endcase
                end
            end
        end
    end

    assign wea        = wea_r;
    assign addra      = addra_r;
    assign dina       = dina_r;
    assign word_count = word_count_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: UART byte driver, write scoreboard and
// session-level status checks with CLK_PER_HALF_BIT=4, ADDR_W=2.
module tb_inst_loader;

    localparam int HALF    = 4;
    localparam int AW      = 2;
    localparam int BIT_CYC = 2 * HALF;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          rxd;
    logic          wea;
    logic [AW-1:0] addra;
    logic [31:0]   dina;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] exp_addr;
    logic          wea_follow = 1'b0;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    inst_loader #(
        .CLK_PER_HALF_BIT(HALF),
        .ADDR_W          (AW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .rxd       (rxd),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        tick(BIT_CYC);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
        end
        send_bit(stop);
        if (!stop) begin
            rxd = 1'b1;
            tick(2 * BIT_CYC);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic expect_write);
        exp_t e;
        if (expect_write) begin
            e.addr = exp_addr;
            e.data = w;
            exp_q.push_back(e);
            exp_addr = exp_addr + 2'd1;
        end
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        check_value("done_timeout", done, 1);
    endtask

    // Write-port monitor: every wea must match the oldest expected write and last one cycle.
    always @(negedge clk) begin
        if (wea_follow) begin
            check_value("wea_one_cycle", wea, 0);
            wea_follow <= 1'b0;
        end else if (wea) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_wea", wea, 0);
            end else begin
                check_value("addra", addra, exp_q[0].addr);
                check_value("dina", dina, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            wea_follow <= 1'b1;
        end
    end

    initial begin
        rstn     = 1'b0;
        start    = 1'b0;
        rxd      = 1'b1;
        exp_addr = 2'd0;
        tick(5);
        check_value("rst_wea", wea, 0);
        check_value("rst_addra", addra, 0);
        check_value("rst_dina", dina, 0);
        check_value("rst_wc", word_count, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_value("rst_err", err, 0);
        rstn = 1'b1;
        tick(100);
        check_value("idle_busy", busy, 0);
        check_value("idle_done", done, 0);
        check_value("idle_err", err, 0);
        check_value("idle_wc", word_count, 0);

        // Basic two-word image
        exp_addr = 2'd0;
        pulse_start();
        check_value("b_busy", busy, 1);
        check_value("b_done0", done, 0);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0000_003F, 1'b1);
        wait_done(2000);
        check_value("b_busy_end", busy, 0);
        check_value("b_wc", word_count, 2);
        check_value("b_err", err, 0);
        check_value("b_sb_empty", exp_q.size(), 0);
        send_word(32'h0403_0201, 1'b0);
        tick(20);
        check_value("b_wc_hold", word_count, 2);
        check_value("b_done_hold", done, 1);

        // Glitch, then framing error, then a valid image in the same session
        exp_addr = 2'd0;
        pulse_start();
        check_value("c_busy", busy, 1);
        check_value("c_wc_clr", word_count, 0);
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(60);
        check_value("c_glitch_err", err, 0);
        check_value("c_glitch_wc", word_count, 0);
        send_byte(8'hAA, 1'b0);
        check_value("c_frame_err", err, 1);
        send_word(32'h0403_0201, 1'b1);
        send_word(32'h0000_003F, 1'b1);
        wait_done(2000);
        check_value("c_err_sticky", err, 1);
        check_value("c_wc", word_count, 2);

        // Reset mid-word with a coincident start, then a fresh image
        exp_addr = 2'd0;
        pulse_start();
        check_value("d_err_clr", err, 0);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        rstn  = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(3);
        check_value("d_rst_busy", busy, 0);
        check_value("d_rst_done", done, 0);
        check_value("d_rst_wc", word_count, 0);
        check_value("d_rst_addra", addra, 0);
        check_value("d_rst_dina", dina, 0);
        exp_addr = 2'd0;
        pulse_start();
        send_word(32'h4433_2211, 1'b1);
        send_word(32'h0000_003F, 1'b1);
        wait_done(2000);
        check_value("d_err", err, 0);
        check_value("d_wc", word_count, 2);

        // Address overflow, with an ignored start while loading
        exp_addr = 2'd0;
        pulse_start();
        send_word(32'hDEAD_BEEF, 1'b1);
        send_word(32'h1234_5678, 1'b1);
        pulse_start();
        send_word(32'hCAFE_F00D, 1'b1);
        send_word(32'h0000_003E, 1'b1);
        wait_done(2000);
        check_value("e_err", err, 1);
        check_value("e_wc", word_count, 4);
        check_value("e_busy", busy, 0);
        send_word(32'h1111_1111, 1'b0);
        tick(20);
        check_value("e_wc_hold", word_count, 4);
        check_value("e_done_hold", done, 1);

        tick(4);
        check_value("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
